// File: rtl/memory_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// memory_arbiter_pkg
//
// Shared definitions for the instruction/data cache memory arbiter:
//   ADDR_W   - block address width (byte address bits [31:4])
//   BLOCK_W  - cache block width
//   arb_state_t - arbiter FSM states (IDLE, GRANT_I, GRANT_D)
//   owner_t     - which cache owns (or last owned) the memory port
//   grant_state - maps a grant owner onto its GRANT_x state
//
// Optional feature macro used by the importing files: ARB_ROUND_ROBIN_EN.
// -----------------------------------------------------------------------------
package memory_arbiter_pkg;

    localparam int ADDR_W  = 28;
    localparam int BLOCK_W = 128;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_t;

    function automatic arb_state_t grant_state(input owner_t owner);
        return (owner == OWNER_D) ? GRANT_D : GRANT_I;
    endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// -----------------------------------------------------------------------------
// memory_arbiter_if
//
// Bundles the three block-transfer buses that meet at the arbiter:
//   i_mem_*  - instruction cache side (read only)
//   d_mem_*  - data cache side (read and write-back)
//   mem_*    - main memory side
//
// Modports:
//   slave  - the arbiter's view (cache requests and memory replies in,
//            memory commands and cache replies out)
//   master - the environment's view (caches + memory model), the mirror image
// -----------------------------------------------------------------------------
interface memory_arbiter_if;

    // Instruction cache
    logic                                     i_mem_Read;
    logic [memory_arbiter_pkg::ADDR_W-1:0]    i_mem_Address;
    logic [memory_arbiter_pkg::BLOCK_W-1:0]   i_mem_Readdata;
    logic                                     i_mem_BusyWait;

    // Data cache
    logic                                     d_mem_Read;
    logic                                     d_mem_Write;
    logic [memory_arbiter_pkg::ADDR_W-1:0]    d_mem_Address;
    logic [memory_arbiter_pkg::BLOCK_W-1:0]   d_mem_Writedata;
    logic [memory_arbiter_pkg::BLOCK_W-1:0]   d_mem_Readdata;
    logic                                     d_mem_BusyWait;

    // Main memory
    logic                                     mem_Read;
    logic                                     mem_Write;
    logic [memory_arbiter_pkg::ADDR_W-1:0]    mem_Address;
    logic [memory_arbiter_pkg::BLOCK_W-1:0]   mem_Writedata;
    logic [memory_arbiter_pkg::BLOCK_W-1:0]   mem_Readdata;
    logic                                     mem_BusyWait;

    modport slave (
        input  i_mem_Read, i_mem_Address,
        output i_mem_Readdata, i_mem_BusyWait,
        input  d_mem_Read, d_mem_Write, d_mem_Address, d_mem_Writedata,
        output d_mem_Readdata, d_mem_BusyWait,
        output mem_Read, mem_Write, mem_Address, mem_Writedata,
        input  mem_Readdata, mem_BusyWait
    );

    modport master (
        output i_mem_Read, i_mem_Address,
        input  i_mem_Readdata, i_mem_BusyWait,
        output d_mem_Read, d_mem_Write, d_mem_Address, d_mem_Writedata,
        input  d_mem_Readdata, d_mem_BusyWait,
        input  mem_Read, mem_Write, mem_Address, mem_Writedata,
        output mem_Readdata, mem_BusyWait
    );

endinterface

// File: rtl/memory_arbiter_arb_select.sv
// -----------------------------------------------------------------------------
// memory_arbiter_arb_select
//
// Purely combinational winner selection for the memory arbiter.
//   i_req       in   instruction cache is requesting
//   d_req       in   data cache is requesting
//   rr_last     in   cache granted most recently (only with ARB_ROUND_ROBIN_EN)
//   grant_valid out  at least one cache is requesting
//   grant_owner out  cache that should be granted
//
// A single requester always wins. On a tie the data cache wins, unless
// ARB_ROUND_ROBIN_EN is defined, in which case the cache that was not granted
// most recently wins.
// -----------------------------------------------------------------------------
module memory_arbiter_arb_select
    import memory_arbiter_pkg::*;
(
    input  logic   i_req,
    input  logic   d_req,
`ifdef ARB_ROUND_ROBIN_EN
    input  owner_t rr_last,
`endif
    output logic   grant_valid,
    output owner_t grant_owner
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        grant_valid = i_req | d_req;
        grant_owner = OWNER_D;

        if (i_req && !d_req) begin
            grant_owner = OWNER_I;
        end
`ifdef ARB_ROUND_ROBIN_EN
        else if (i_req && d_req) begin
            grant_owner = (rr_last == OWNER_D) ? OWNER_I : OWNER_D;
        end
`endif
    end

endmodule

// File: rtl/memory_arbiter.sv
// -----------------------------------------------------------------------------
// memory_arbiter
//
// Shares the single 128-bit-block main memory between the instruction cache
// and the data cache. One cache is granted at a time; its block request is
// steered to memory and the memory's read data / busywait are returned to it,
// while the other cache is held in busywait.
//
// Ports:
//   clock  in   system clock, all state on posedge
//   reset  in   synchronous, active-high
//   bus    slave modport of memory_arbiter_if (both cache buses + memory bus)
//
// Configuration macro: ARB_ROUND_ROBIN_EN
//   undefined - fixed priority, data cache wins every tie, no pointer register
//   defined   - on a tie grant the cache not granted most recently
//
// Transaction shape: a request seen in IDLE is granted on the next edge, so
// the memory command appears one cycle after the request is sampled. The
// grant ends on the first cycle where memory is not busy after having been
// busy at least once (seen_busy), because memory only raises busywait a cycle
// after it sees the command. After completion the FSM always spends one cycle
// in IDLE before the next grant.
// -----------------------------------------------------------------------------
module memory_arbiter
    import memory_arbiter_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    memory_arbiter_if.slave  bus
);

    // ------------------------------------------------------------------
    // Requests and arbitration
    // ------------------------------------------------------------------
    logic   i_req;
    logic   d_req;
    logic   grant_valid;
    owner_t grant_owner;

    assign i_req = bus.i_mem_Read;
    assign d_req = bus.d_mem_Read | bus.d_mem_Write;

    arb_state_t state_q, state_d;
    logic       seen_busy_q, seen_busy_d;

`ifdef ARB_ROUND_ROBIN_EN
    owner_t     rr_last_q, rr_last_d;
`endif

    memory_arbiter_arb_select u_arb_select (
        .i_req       (i_req),
        .d_req       (d_req),
`ifdef ARB_ROUND_ROBIN_EN
        .rr_last     (rr_last_q),
`endif
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    // ------------------------------------------------------------------
    // Grant status
    // ------------------------------------------------------------------
    logic granted_i;
    logic granted_d;
    logic completion;

    assign granted_i  = (state_q == GRANT_I);
    assign granted_d  = (state_q == GRANT_D);
    // A grant cannot end before memory has acknowledged with busywait.
    assign completion = (granted_i | granted_d) & seen_busy_q & ~bus.mem_BusyWait;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        seen_busy_d = seen_busy_q;
`ifdef ARB_ROUND_ROBIN_EN
        rr_last_d   = rr_last_q;
`endif

        case (state_q)
            IDLE: begin
                seen_busy_d = 1'b0;
                if (grant_valid) begin
                    state_d = grant_state(grant_owner);
`ifdef ARB_ROUND_ROBIN_EN
                    rr_last_d = grant_owner;
`endif
                end
            end

            // The grant is held until completion even if the requester
            // drops its request: a memory transaction cannot be aborted.
            GRANT_I, GRANT_D: begin
                if (completion) begin
                    state_d     = IDLE;
                    seen_busy_d = 1'b0;
                end else if (bus.mem_BusyWait) begin
                    seen_busy_d = 1'b1;
                end
            end

            default: begin
                state_d     = IDLE;
                seen_busy_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values; reset is synchronous, so it is simply the
    // first branch inside the clocked block, not in the sensitivity list.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            seen_busy_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            // I-last, so the data cache wins the first tie after reset.
            rr_last_q   <= OWNER_I;
`endif
        end else begin
            state_q     <= state_d;
            seen_busy_q <= seen_busy_d;
`ifdef ARB_ROUND_ROBIN_EN
            rr_last_q   <= rr_last_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Memory-side steering: the winner drives memory, nothing else does.
    // ------------------------------------------------------------------
    always_comb begin
        bus.mem_Read      = 1'b0;
        bus.mem_Write     = 1'b0;
        bus.mem_Address   = '0;
        bus.mem_Writedata = '0;

        case (state_q)
            GRANT_I: begin
                bus.mem_Read    = bus.i_mem_Read;
                bus.mem_Address = bus.i_mem_Address;
            end
            GRANT_D: begin
                // Read and write together is treated as a write-back.
                bus.mem_Write     = bus.d_mem_Write;
                bus.mem_Read      = bus.d_mem_Read & ~bus.d_mem_Write;
                bus.mem_Address   = bus.d_mem_Address;
                bus.mem_Writedata = bus.d_mem_Writedata;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Cache-side replies
    // ------------------------------------------------------------------
    // Busywait follows the request and drops only on the owner's completion
    // cycle, so the losing cache stalls through the whole winning transfer.
    assign bus.i_mem_BusyWait = i_req & ~(granted_i & completion);
    assign bus.d_mem_BusyWait = d_req & ~(granted_d & completion);

    assign bus.i_mem_Readdata = granted_i ? bus.mem_Readdata : '0;
    assign bus.d_mem_Readdata = granted_d ? bus.mem_Readdata : '0;

endmodule

// File: tb/tb_memory_arbiter.sv
// -----------------------------------------------------------------------------
// tb_memory_arbiter
//
// Directed bench for memory_arbiter. A small memory model raises busywait for
// BUSY_CYCLES cycles starting the cycle after it sees a new command, so each
// transfer completes on the fifth cycle after the grant cycle.
// Expected grant order on ties depends on ARB_ROUND_ROBIN_EN.
// -----------------------------------------------------------------------------
module tb_memory_arbiter;
    import memory_arbiter_pkg::*;

    localparam int BUSY_CYCLES = 4;
    localparam int TIMEOUT     = 30;
    localparam int DONE_CYCLES = BUSY_CYCLES + 1;

    logic clock = 1'b0;
    logic reset;

    int total = 0;
    int bad   = 0;

    memory_arbiter_if bus ();

    memory_arbiter dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    // ------------------------------------------------------------------
    // Memory model: busy for BUSY_CYCLES cycles after a rising command.
    // ------------------------------------------------------------------
    int   busy_cnt;
    logic cmd_prev;
    logic cmd_now;

    assign cmd_now          = bus.mem_Read | bus.mem_Write;
    assign bus.mem_BusyWait = (busy_cnt != 0);

    always @(posedge clock) begin
        if (reset) begin
            busy_cnt <= 0;
            cmd_prev <= 1'b0;
        end else begin
            cmd_prev <= cmd_now;
            if (cmd_now && !cmd_prev) busy_cnt <= BUSY_CYCLES;
            else if (busy_cnt != 0)   busy_cnt <= busy_cnt - 1;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic drive_idle();
        bus.i_mem_Read      = 1'b0;
        bus.i_mem_Address   = '0;
        bus.d_mem_Read      = 1'b0;
        bus.d_mem_Write     = 1'b0;
        bus.d_mem_Address   = '0;
        bus.d_mem_Writedata = '0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        drive_idle();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    // Waits (bounded) for the selected cache's busywait to drop. Returns the
    // number of negedges waited (-1 on timeout) and how many of those cycles
    // saw the other cache's busywait low.
    task automatic wait_done(input bit is_d, output int cycles, output int other_low);
        int  c;
        logic own_busy;
        logic other_busy;
        c         = 0;
        cycles    = -1;
        other_low = 0;
        while (cycles < 0 && c < TIMEOUT) begin
            @(negedge clock);
            c++;
            own_busy   = is_d ? bus.d_mem_BusyWait : bus.i_mem_BusyWait;
            other_busy = is_d ? bus.i_mem_BusyWait : bus.d_mem_BusyWait;
            if (!other_busy) other_low++;
            if (!own_busy) cycles = c;
        end
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        drive_idle();
        bus.i_mem_Read   = 1'b1;
        bus.mem_Readdata = {16{8'h5A}};
        repeat (2) @(negedge clock);
        total++; if (bus.mem_Read !== 1'b0) begin bad++; $display("FAIL reset_mem_read got=%0b exp=0", bus.mem_Read); end
        total++; if (bus.mem_Write !== 1'b0) begin bad++; $display("FAIL reset_mem_write got=%0b exp=0", bus.mem_Write); end
        total++; if (bus.mem_Address !== 28'h0) begin bad++; $display("FAIL reset_mem_addr got=%h exp=0", bus.mem_Address); end
        total++; if (bus.mem_Writedata !== 128'h0) begin bad++; $display("FAIL reset_mem_wdata got=%h exp=0", bus.mem_Writedata); end
        total++; if (bus.i_mem_Readdata !== 128'h0) begin bad++; $display("FAIL reset_i_rdata got=%h exp=0", bus.i_mem_Readdata); end
        total++; if (bus.d_mem_Readdata !== 128'h0) begin bad++; $display("FAIL reset_d_rdata got=%h exp=0", bus.d_mem_Readdata); end
        total++; if (bus.i_mem_BusyWait !== 1'b1) begin bad++; $display("FAIL reset_i_busy got=%0b exp=1", bus.i_mem_BusyWait); end
        total++; if (bus.d_mem_BusyWait !== 1'b0) begin bad++; $display("FAIL reset_d_busy got=%0b exp=0", bus.d_mem_BusyWait); end
        drive_idle();
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_i_read();
        int cyc;
        int other_low;
        bus.mem_Readdata  = {16{8'hA5}};
        bus.i_mem_Read    = 1'b1;
        bus.i_mem_Address = 28'h0000010;
        #1;
        total++; if (bus.i_mem_BusyWait !== 1'b1) begin bad++; $display("FAIL iread_idle_busy got=%0b exp=1", bus.i_mem_BusyWait); end
        total++; if (bus.mem_Read !== 1'b0) begin bad++; $display("FAIL iread_idle_no_cmd got=%0b exp=0", bus.mem_Read); end
        @(negedge clock);
        total++; if (bus.mem_Read !== 1'b1) begin bad++; $display("FAIL iread_mem_read got=%0b exp=1", bus.mem_Read); end
        total++; if (bus.mem_Write !== 1'b0) begin bad++; $display("FAIL iread_mem_write got=%0b exp=0", bus.mem_Write); end
        total++; if (bus.mem_Address !== 28'h0000010) begin bad++; $display("FAIL iread_mem_addr got=%h exp=0000010", bus.mem_Address); end
        wait_done(1'b0, cyc, other_low);
        total++; if (cyc !== DONE_CYCLES) begin bad++; $display("FAIL iread_latency got=%0d exp=%0d", cyc, DONE_CYCLES); end
        total++; if (bus.i_mem_Readdata !== {16{8'hA5}}) begin bad++; $display("FAIL iread_rdata got=%h exp=%h", bus.i_mem_Readdata, {16{8'hA5}}); end
        total++; if (bus.d_mem_Readdata !== 128'h0) begin bad++; $display("FAIL iread_d_rdata got=%h exp=0", bus.d_mem_Readdata); end
        total++; if (bus.d_mem_BusyWait !== 1'b0) begin bad++; $display("FAIL iread_d_busy got=%0b exp=0", bus.d_mem_BusyWait); end
        drive_idle();
        @(negedge clock);
        total++; if (bus.mem_Read !== 1'b0) begin bad++; $display("FAIL iread_back_idle got=%0b exp=0", bus.mem_Read); end
    endtask

    task automatic test_d_write();
        int cyc;
        int other_low;
        logic [BLOCK_W-1:0] wdata;
        wdata               = {8{16'h1234}};
        bus.d_mem_Write     = 1'b1;
        bus.d_mem_Address   = 28'h0000020;
        bus.d_mem_Writedata = wdata;
        @(negedge clock);
        total++; if (bus.mem_Write !== 1'b1) begin bad++; $display("FAIL dwrite_mem_write got=%0b exp=1", bus.mem_Write); end
        total++; if (bus.mem_Read !== 1'b0) begin bad++; $display("FAIL dwrite_mem_read got=%0b exp=0", bus.mem_Read); end
        total++; if (bus.mem_Address !== 28'h0000020) begin bad++; $display("FAIL dwrite_mem_addr got=%h exp=0000020", bus.mem_Address); end
        total++; if (bus.mem_Writedata !== wdata) begin bad++; $display("FAIL dwrite_wdata got=%h exp=%h", bus.mem_Writedata, wdata); end
        total++; if (bus.i_mem_BusyWait !== 1'b0) begin bad++; $display("FAIL dwrite_i_busy got=%0b exp=0", bus.i_mem_BusyWait); end
        wait_done(1'b1, cyc, other_low);
        total++; if (cyc !== DONE_CYCLES) begin bad++; $display("FAIL dwrite_latency got=%0d exp=%0d", cyc, DONE_CYCLES); end
        drive_idle();
        @(negedge clock);
    endtask

    // Tie from reset: D first (both modes), I stalls, then I after one IDLE.
    task automatic test_tie_then_serve();
        int cyc;
        int other_low;
        apply_reset();
        bus.mem_Readdata  = {4{32'hD0D0D0D0}};
        bus.i_mem_Read    = 1'b1;
        bus.i_mem_Address = 28'h0000030;
        bus.d_mem_Read    = 1'b1;
        bus.d_mem_Address = 28'h0000040;
        @(negedge clock);
        total++; if (bus.mem_Address !== 28'h0000040) begin bad++; $display("FAIL tie_first_addr got=%h exp=0000040", bus.mem_Address); end
        total++; if (bus.i_mem_Readdata !== 128'h0) begin bad++; $display("FAIL tie_loser_rdata got=%h exp=0", bus.i_mem_Readdata); end
        wait_done(1'b1, cyc, other_low);
        total++; if (cyc !== DONE_CYCLES) begin bad++; $display("FAIL tie_d_latency got=%0d exp=%0d", cyc, DONE_CYCLES); end
        total++; if (other_low !== 0) begin bad++; $display("FAIL tie_i_stall got=%0d low cycles exp=0", other_low); end
        total++; if (bus.d_mem_Readdata !== {4{32'hD0D0D0D0}}) begin bad++; $display("FAIL tie_d_rdata got=%h exp=%h", bus.d_mem_Readdata, {4{32'hD0D0D0D0}}); end
        bus.d_mem_Read   = 1'b0;
        bus.mem_Readdata = {4{32'h1C1C1C1C}};
        @(negedge clock);
        total++; if (bus.mem_Read !== 1'b0) begin bad++; $display("FAIL tie_gap_idle got=%0b exp=0", bus.mem_Read); end
        total++; if (bus.i_mem_BusyWait !== 1'b1) begin bad++; $display("FAIL tie_gap_i_busy got=%0b exp=1", bus.i_mem_BusyWait); end
        @(negedge clock);
        total++; if (bus.mem_Address !== 28'h0000030 || bus.mem_Read !== 1'b1) begin bad++; $display("FAIL tie_second_grant got addr=%h rd=%0b exp addr=0000030 rd=1", bus.mem_Address, bus.mem_Read); end
        wait_done(1'b0, cyc, other_low);
        total++; if (cyc !== DONE_CYCLES) begin bad++; $display("FAIL tie_i_latency got=%0d exp=%0d", cyc, DONE_CYCLES); end
        total++; if (bus.i_mem_Readdata !== {4{32'h1C1C1C1C}}) begin bad++; $display("FAIL tie_i_rdata got=%h exp=%h", bus.i_mem_Readdata, {4{32'h1C1C1C1C}}); end
        drive_idle();
        @(negedge clock);
    endtask

    // Three ties in a row, both requests dropped after each winner finishes.
    // Previous grant was I, so round robin yields D, I, D.
    task automatic test_repeated_ties();
        owner_t exp_winner [3];
        int cyc;
        int other_low;
`ifdef ARB_ROUND_ROBIN_EN
        exp_winner = '{OWNER_D, OWNER_I, OWNER_D};
`else
        exp_winner = '{OWNER_D, OWNER_D, OWNER_D};
`endif
        for (int k = 0; k < 3; k++) begin
            logic [ADDR_W-1:0] exp_addr;
            exp_addr          = (exp_winner[k] == OWNER_D) ? 28'h0000040 : 28'h0000030;
            bus.i_mem_Read    = 1'b1;
            bus.i_mem_Address = 28'h0000030;
            bus.d_mem_Read    = 1'b1;
            bus.d_mem_Address = 28'h0000040;
            @(negedge clock);
            total++; if (bus.mem_Address !== exp_addr) begin bad++; $display("FAIL ties_%0d_winner got=%h exp=%h", k, bus.mem_Address, exp_addr); end
            wait_done(exp_winner[k] == OWNER_D, cyc, other_low);
            total++; if (cyc !== DONE_CYCLES || other_low !== 0) begin bad++; $display("FAIL ties_%0d_done got cyc=%0d loser_low=%0d exp cyc=%0d loser_low=0", k, cyc, other_low, DONE_CYCLES); end
            drive_idle();
            @(negedge clock);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        int other_low;
        bus.d_mem_Read    = 1'b1;
        bus.d_mem_Address = 28'h0000050;
        @(negedge clock);
        total++; if (bus.mem_Address !== 28'h0000050) begin bad++; $display("FAIL rstmid_d_grant got=%h exp=0000050", bus.mem_Address); end
        bus.i_mem_Read    = 1'b1;
        bus.i_mem_Address = 28'h0000060;
        @(negedge clock);
        reset          = 1'b1;
        bus.d_mem_Read = 1'b0;
        @(negedge clock);
        total++; if (bus.mem_Read !== 1'b0 || bus.mem_Write !== 1'b0) begin bad++; $display("FAIL rstmid_cmd got rd=%0b wr=%0b exp 0 0", bus.mem_Read, bus.mem_Write); end
        total++; if (bus.mem_Address !== 28'h0) begin bad++; $display("FAIL rstmid_addr got=%h exp=0", bus.mem_Address); end
        total++; if (bus.d_mem_Readdata !== 128'h0 || bus.i_mem_Readdata !== 128'h0) begin bad++; $display("FAIL rstmid_rdata got d=%h i=%h exp 0", bus.d_mem_Readdata, bus.i_mem_Readdata); end
        total++; if (bus.i_mem_BusyWait !== 1'b1) begin bad++; $display("FAIL rstmid_i_busy got=%0b exp=1", bus.i_mem_BusyWait); end
        reset = 1'b0;
        @(negedge clock);
        total++; if (bus.mem_Address !== 28'h0000060 || bus.mem_Read !== 1'b1) begin bad++; $display("FAIL rstmid_i_grant got addr=%h rd=%0b exp addr=0000060 rd=1", bus.mem_Address, bus.mem_Read); end
        wait_done(1'b0, cyc, other_low);
        total++; if (cyc !== DONE_CYCLES) begin bad++; $display("FAIL rstmid_i_latency got=%0d exp=%0d", cyc, DONE_CYCLES); end
        drive_idle();
        @(negedge clock);
    endtask

    task automatic test_read_write_both();
        int cyc;
        int other_low;
        bus.d_mem_Read      = 1'b1;
        bus.d_mem_Write     = 1'b1;
        bus.d_mem_Address   = 28'h0000070;
        bus.d_mem_Writedata = {4{32'hCAFEF00D}};
        @(negedge clock);
        total++; if (bus.mem_Write !== 1'b1) begin bad++; $display("FAIL rw_mem_write got=%0b exp=1", bus.mem_Write); end
        total++; if (bus.mem_Read !== 1'b0) begin bad++; $display("FAIL rw_mem_read got=%0b exp=0", bus.mem_Read); end
        total++; if (bus.mem_Address !== 28'h0000070) begin bad++; $display("FAIL rw_mem_addr got=%h exp=0000070", bus.mem_Address); end
        wait_done(1'b1, cyc, other_low);
        total++; if (cyc !== DONE_CYCLES) begin bad++; $display("FAIL rw_latency got=%0d exp=%0d", cyc, DONE_CYCLES); end
        drive_idle();
        @(negedge clock);
    endtask

    // ------------------------------------------------------------------
    // Sequence
    // ------------------------------------------------------------------
    initial begin
        reset = 1'b1;
        drive_idle();
        bus.mem_Readdata = '0;
        test_reset();
        test_i_read();
        test_d_write();
        test_tie_then_serve();
        test_repeated_ties();
        test_reset_mid();
        test_read_write_both();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
